calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, the maximum digits accepted per operand (range 1..15).
REQ-002 SHALL have parameter EXEC_TIMEOUT, default 16, the maximum cycles to wait for alu_done_in before declaring an error (range 2..255).
REQ-003 clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset; synchronous, active-low.
REQ-005 dig_in, op_in, ex_in, bksp_in, clear_in, ms_in, mr_in, mc_in  input  1 each  single-cycle key strobes, already debounced upstream.
REQ-006 alu_done_in  input  1  ALU result valid pulse; alu_err_in  input  1  ALU error qualifier, sampled only with alu_done_in.
REQ-007 load_A, load_B, bksp_A, bksp_B, load_op, load_A_from_result, clear_regs  output  1 each  datapath strobes.
REQ-008 execute  output  1  one-cycle ALU start pulse.
REQ-009 mem_store, mem_recall_A, mem_recall_B, mem_clear  output  1 each  memory-register strobes.
REQ-010 mem_valid, busy, error  output  1 each  registered status flags.
REQ-011 count_A, count_B  output  4  registered digit counts of each operand.
REQ-012 display_select  output  2  display source: 0 = A, 1 = B, 2 = result, 3 = error.

Function
REQ-013 SHALL implement the states ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT and ERR.
REQ-014 Strobe outputs SHALL be combinational from the current state and the inputs, asserted in the same cycle as the causing key, and 0 otherwise.
REQ-015 When several keys are high in one cycle, only one SHALL be acted on, in priority order: clear > ex > op > mr > ms > mc > dig > bksp.
REQ-016 clear_in in any state SHALL pulse clear_regs, zero both counts and move to ENTER_A; in EXEC it aborts the operation, and a later alu_done_in is ignored.
REQ-017 In ENTER_A:
  - dig with count_A<MAX_DIGITS: load_A, count_A+1.
  - dig at MAX_DIGITS: ignored.
  - bksp with count_A>0: bksp_A, count_A-1.
  - op with count_A>0: load_op, move to OP_WAIT.
  - op with count_A=0: ignored.
REQ-018 In OP_WAIT:
  - op: load_op (operator replaced), stay.
  - dig: load_B, count_B=1, move to ENTER_B.
  - bksp: move to ENTER_A with no strobe.
REQ-019 In ENTER_B:
  - dig and bksp: as REQ-017, but on B.
  - bksp with count_B=0: move to OP_WAIT.
  - ex with count_B>0: execute, move to EXEC.
  - ex with count_B=0: ignored.
REQ-020 In EXEC:
  - busy=1; all keys except clear are ignored.
  - A cycle timer starts at 0 on entry.
  - alu_done_in with !alu_err_in: move to RESULT.
  - alu_done_in with alu_err_in: move to ERR.
  - Timer reaching EXEC_TIMEOUT-1 without done: move to ERR.
REQ-021 In RESULT:
  - dig: clear_regs and load_A in the same cycle, count_A=1, count_B=0, move to ENTER_A.
  - op: load_A_from_result and load_op, count_A=MAX_DIGITS, count_B=0, move to OP_WAIT (chaining).
  - ms: mem_store, mem_valid<=1.
REQ-022 In ERR: error=1; only clear_in is acted on.
REQ-023 mr in ENTER_A or ENTER_B with mem_valid=1 SHALL pulse mem_recall_A or mem_recall_B respectively and set that count to MAX_DIGITS; with mem_valid=0 it is ignored.
REQ-024 mc in any state except EXEC and ERR SHALL pulse mem_clear and set mem_valid<=0.
REQ-025 display_select SHALL be derived from state as follows: ENTER_A/OP_WAIT -> 0, ENTER_B -> 1, EXEC/RESULT -> 2, ERR -> 3.
REQ-026 Counts SHALL saturate and never wrap: no increment at MAX_DIGITS, no decrement at 0.

Reset
REQ-027 reset_n=0 at a rising clock edge SHALL force ENTER_A, count_A=count_B=0, timer=0 and mem_valid=busy=error=0.
REQ-028 During reset all strobes SHALL be 0 and display_select SHALL be 0; reset overrides every key and alu_done_in.

Structure
REQ-029 Package calc_pkg SHALL hold the state enumeration, the display_select codes and the count width constant.
REQ-030 A sub-module digit_counter SHALL provide the saturating up/down counter with load-to-1, load-to-max and clear, instantiated once for A and once for B.

Verification
REQ-031 Bench: reset, then dig x5 with MAX_DIGITS=4 -> load_A on the first 4 digits only, count_A=4; bksp x5 -> bksp_A x4, count_A=0.
REQ-032 Bench: dig, op, dig, ex, then alu_done_in after 3 cycles -> execute pulses once, busy=1 for 3 cycles, display_select=2 in RESULT.
REQ-033 Bench: ex, then no alu_done_in for 16 cycles -> ERR, error=1, display_select=3; dig ignored; clear -> ENTER_A, clear_regs pulse.
REQ-034 Bench: reach RESULT, ms -> mem_valid=1; clear; mr -> mem_recall_A and count_A=4; mc -> mem_valid=0, and a further mr is ignored.
REQ-035 Bench: in RESULT, op -> load_A_from_result and load_op in the same cycle, OP_WAIT; op and dig in the same cycle -> only load_op fires.
REQ-036 Bench: clear during EXEC, then a late alu_done_in -> ENTER_A held, with no transition to RESULT.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package calc_pkg;

  // Width of the per-operand digit counters (holds up to 15 digits).
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    OP_WAIT  = 3'd1,
    ENTER_B  = 3'd2,
    EXEC     = 3'd3,
    RESULT   = 3'd4,
    ERR      = 3'd5
  } state_t;

  // display_select codes
  localparam logic [1:0] DISP_A      = 2'd0;
  localparam logic [1:0] DISP_B      = 2'd1;
  localparam logic [1:0] DISP_RESULT = 2'd2;
  localparam logic [1:0] DISP_ERR    = 2'd3;

  // Map a sequencer state onto the display source it shows.
  function automatic logic [1:0] disp_of(input state_t s);
    logic [1:0] d;
    d = DISP_A;
    case (s)
      ENTER_A, OP_WAIT: d = DISP_A;
      ENTER_B:          d = DISP_B;
      EXEC, RESULT:     d = DISP_RESULT;
      ERR:              d = DISP_ERR;
      default:          d = DISP_A;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_sequencer_digit_counter.sv
// Saturating operand digit counter with clear, load-to-1 and load-to-max.
// Latency: count updates on the clock edge after the control strobe.
// Backpressure: none; increments at MAX and decrements at 0 are dropped.
module digit_counter
  import calc_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load_one,
  input  logic             load_max,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  // Counter register: clear wins over loads, loads over inc/dec; never wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load_one) begin
      count <= CNT_W'(1);
    end else if (load_max) begin
      count <= MAX_C;
    end else if (inc && (count < MAX_C)) begin
      count <= count + CNT_W'(1);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: turns key strobes into datapath/ALU/memory strobes.
// Latency: strobes are combinational in the key cycle; status/counts update next edge.
// Backpressure: none; keys not valid in the current state are dropped (EXEC/ERR honour only clear).
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS   = 4,
  parameter int EXEC_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dig_in,
  input  logic             op_in,
  input  logic             ex_in,
  input  logic             bksp_in,
  input  logic             clear_in,
  input  logic             ms_in,
  input  logic             mr_in,
  input  logic             mc_in,
  input  logic             alu_done_in,
  input  logic             alu_err_in,
  output logic             load_A,
  output logic             load_B,
  output logic             bksp_A,
  output logic             bksp_B,
  output logic             load_op,
  output logic             load_A_from_result,
  output logic             clear_regs,
  output logic             execute,
  output logic             mem_store,
  output logic             mem_recall_A,
  output logic             mem_recall_B,
  output logic             mem_clear,
  output logic             mem_valid,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] count_A,
  output logic [CNT_W-1:0] count_B,
  output logic [1:0]       display_select
);

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_DIGITS);
  localparam logic [7:0]       T_LAST  = 8'(EXEC_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] timer;
  logic       inc_a, dec_a, one_a, max_a, clr_a;
  logic       inc_b, dec_b, one_b, max_b, clr_b;
  logic       mem_set, mem_clr;

  // State, EXEC timer and status flags; busy/error track the state being entered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ENTER_A;
      timer     <= '0;
      mem_valid <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= (state == EXEC && state_next == EXEC) ? timer + 8'd1 : 8'd0;
      busy      <= (state_next == EXEC);
      error     <= (state_next == ERR);
      if (mem_set)      mem_valid <= 1'b1;
      else if (mem_clr) mem_valid <= 1'b0;
    end
  end

  // Next state and strobes: clear first, then one key per cycle in priority
  // order ex > op > mr > ms > mc > dig > bksp; the winning key may still be a no-op.
  always_comb begin
    state_next         = state;
    load_A             = 1'b0;
    load_B             = 1'b0;
    bksp_A             = 1'b0;
    bksp_B             = 1'b0;
    load_op            = 1'b0;
    load_A_from_result = 1'b0;
    clear_regs         = 1'b0;
    execute            = 1'b0;
    mem_store          = 1'b0;
    mem_recall_A       = 1'b0;
    mem_recall_B       = 1'b0;
    mem_clear          = 1'b0;
    inc_a = 1'b0; dec_a = 1'b0; one_a = 1'b0; max_a = 1'b0; clr_a = 1'b0;
    inc_b = 1'b0; dec_b = 1'b0; one_b = 1'b0; max_b = 1'b0; clr_b = 1'b0;
    mem_set = 1'b0;
    mem_clr = 1'b0;

    if (clear_in) begin
      clear_regs = 1'b1;
      clr_a      = 1'b1;
      clr_b      = 1'b1;
      state_next = ENTER_A;
    end else begin
      case (state)
        ENTER_A: begin
          if (ex_in) begin
            // no operand B yet
          end else if (op_in) begin
            if (count_A != '0) begin
              load_op    = 1'b1;
              state_next = OP_WAIT;
            end
          end else if (mr_in) begin
            if (mem_valid) begin
              mem_recall_A = 1'b1;
              max_a        = 1'b1;
            end
          end else if (ms_in) begin
            // only meaningful in RESULT
          end else if (mc_in) begin
            mem_clear = 1'b1;
            mem_clr   = 1'b1;
          end else if (dig_in) begin
            if (count_A < MAX_C) begin
              load_A = 1'b1;
              inc_a  = 1'b1;
            end
          end else if (bksp_in) begin
            if (count_A != '0) begin
              bksp_A = 1'b1;
              dec_a  = 1'b1;
            end
          end
        end

        OP_WAIT: begin
          if (ex_in) begin
            // no operand B yet
          end else if (op_in) begin
            load_op = 1'b1;
          end else if (mr_in || ms_in) begin
            // recall needs an operand-entry state; store needs a result
          end else if (mc_in) begin
            mem_clear = 1'b1;
            mem_clr   = 1'b1;
          end else if (dig_in) begin
            load_B     = 1'b1;
            one_b      = 1'b1;
            state_next = ENTER_B;
          end else if (bksp_in) begin
            state_next = ENTER_A;
          end
        end

        ENTER_B: begin
          if (ex_in) begin
            if (count_B != '0) begin
              execute    = 1'b1;
              state_next = EXEC;
            end
          end else if (op_in) begin
            // operator is locked once B entry has started
          end else if (mr_in) begin
            if (mem_valid) begin
              mem_recall_B = 1'b1;
              max_b        = 1'b1;
            end
          end else if (ms_in) begin
            // only meaningful in RESULT
          end else if (mc_in) begin
            mem_clear = 1'b1;
            mem_clr   = 1'b1;
          end else if (dig_in) begin
            if (count_B < MAX_C) begin
              load_B = 1'b1;
              inc_b  = 1'b1;
            end
          end else if (bksp_in) begin
            if (count_B != '0) begin
              bksp_B = 1'b1;
              dec_b  = 1'b1;
            end else begin
              state_next = OP_WAIT;
            end
          end
        end

        EXEC: begin
          if (alu_done_in) begin
            state_next = alu_err_in ? ERR : RESULT;
          end else if (timer == T_LAST) begin
            state_next = ERR;
          end
        end

        RESULT: begin
          if (ex_in) begin
            // nothing to execute
          end else if (op_in) begin
            load_A_from_result = 1'b1;
            load_op            = 1'b1;
            max_a              = 1'b1;
            clr_b              = 1'b1;
            state_next         = OP_WAIT;
          end else if (mr_in) begin
            // recall needs an operand-entry state
          end else if (ms_in) begin
            mem_store = 1'b1;
            mem_set   = 1'b1;
          end else if (mc_in) begin
            mem_clear = 1'b1;
            mem_clr   = 1'b1;
          end else if (dig_in) begin
            clear_regs = 1'b1;
            load_A     = 1'b1;
            one_a      = 1'b1;
            clr_b      = 1'b1;
            state_next = ENTER_A;
          end
        end

        ERR: begin
          // only clear leaves ERR
        end

        default: state_next = ENTER_A;
      endcase
    end

    // Reset silences every strobe regardless of keys or ALU handshake.
    if (!reset_n) begin
      load_A             = 1'b0;
      load_B             = 1'b0;
      bksp_A             = 1'b0;
      bksp_B             = 1'b0;
      load_op            = 1'b0;
      load_A_from_result = 1'b0;
      clear_regs         = 1'b0;
      execute            = 1'b0;
      mem_store          = 1'b0;
      mem_recall_A       = 1'b0;
      mem_recall_B       = 1'b0;
      mem_clear          = 1'b0;
    end
  end

  // Display source follows the state, forced to operand A while in reset.
  always_comb begin
    display_select = reset_n ? disp_of(state) : DISP_A;
  end

  digit_counter #(.MAX(MAX_DIGITS)) u_cnt_a (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc      (inc_a),
    .dec      (dec_a),
    .load_one (one_a),
    .load_max (max_a),
    .clr      (clr_a),
    .count    (count_A)
  );

  digit_counter #(.MAX(MAX_DIGITS)) u_cnt_b (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc      (inc_b),
    .dec      (dec_b),
    .load_one (one_b),
    .load_max (max_b),
    .clr      (clr_b),
    .count    (count_B)
  );

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer (MAX_DIGITS=4, EXEC_TIMEOUT=16).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later / after the rising edge.
// Backpressure: n/a.
module tb_calc_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic dig_in, op_in, ex_in, bksp_in, clear_in, ms_in, mr_in, mc_in;
  logic alu_done_in, alu_err_in;
  logic load_A, load_B, bksp_A, bksp_B, load_op, load_A_from_result, clear_regs, execute;
  logic mem_store, mem_recall_A, mem_recall_B, mem_clear;
  logic mem_valid, busy, error;
  logic [3:0] count_A, count_B;
  logic [1:0] display_select;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.MAX_DIGITS(4), .EXEC_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .dig_in(dig_in), .op_in(op_in), .ex_in(ex_in), .bksp_in(bksp_in),
    .clear_in(clear_in), .ms_in(ms_in), .mr_in(mr_in), .mc_in(mc_in),
    .alu_done_in(alu_done_in), .alu_err_in(alu_err_in),
    .load_A(load_A), .load_B(load_B), .bksp_A(bksp_A), .bksp_B(bksp_B),
    .load_op(load_op), .load_A_from_result(load_A_from_result),
    .clear_regs(clear_regs), .execute(execute),
    .mem_store(mem_store), .mem_recall_A(mem_recall_A), .mem_recall_B(mem_recall_B),
    .mem_clear(mem_clear), .mem_valid(mem_valid), .busy(busy), .error(error),
    .count_A(count_A), .count_B(count_B), .display_select(display_select)
  );

  logic [11:0] strb;
  assign strb = {load_A, load_B, bksp_A, bksp_B, load_op, load_A_from_result,
                 clear_regs, execute, mem_store, mem_recall_A, mem_recall_B, mem_clear};

  localparam logic [11:0] S_NONE = 12'h000;
  localparam logic [11:0] S_LA   = 12'h800;
  localparam logic [11:0] S_LB   = 12'h400;
  localparam logic [11:0] S_BA   = 12'h200;
  localparam logic [11:0] S_BB   = 12'h100;
  localparam logic [11:0] S_LOP  = 12'h080;
  localparam logic [11:0] S_LAFR = 12'h040;
  localparam logic [11:0] S_CLR  = 12'h020;
  localparam logic [11:0] S_EXE  = 12'h010;
  localparam logic [11:0] S_MST  = 12'h008;
  localparam logic [11:0] S_MRA  = 12'h004;
  localparam logic [11:0] S_MRB  = 12'h002;
  localparam logic [11:0] S_MCL  = 12'h001;

  localparam logic [7:0] K_NONE = 8'h00;
  localparam logic [7:0] K_CLR  = 8'h80;
  localparam logic [7:0] K_EX   = 8'h40;
  localparam logic [7:0] K_OP   = 8'h20;
  localparam logic [7:0] K_MR   = 8'h10;
  localparam logic [7:0] K_MS   = 8'h08;
  localparam logic [7:0] K_MC   = 8'h04;
  localparam logic [7:0] K_DIG  = 8'h02;
  localparam logic [7:0] K_BK   = 8'h01;

  task automatic set_keys(input logic [7:0] k);
    {clear_in, ex_in, op_in, mr_in, ms_in, mc_in, dig_in, bksp_in} = k;
  endtask

  // Drive keys/ALU handshake on the falling edge; return 1 unit later for strobe checks.
  task automatic apply(input logic [7:0] k, input logic done, input logic err);
    @(negedge clock);
    set_keys(k);
    alu_done_in = done;
    alu_err_in  = err;
    #1;
  endtask

  // Commit the cycle on the rising edge, then release all inputs.
  task automatic tick();
    @(posedge clock);
    #1;
    set_keys(K_NONE);
    alu_done_in = 1'b0;
    alu_err_in  = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    apply(k, 1'b0, 1'b0);
    tick();
  endtask

  // Clear, enter one digit each for A and B, press ex: leaves the DUT in EXEC.
  task automatic go_exec();
    press(K_CLR);
    press(K_DIG);
    press(K_OP);
    press(K_DIG);
    press(K_EX);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    apply(8'hFF, 1'b1, 1'b0);
    checks++; if (strb !== S_NONE) begin errors++; $display("FAIL reset_strobes: got %h expected %h", strb, S_NONE); end
    checks++; if (display_select !== 2'd0) begin errors++; $display("FAIL reset_disp: got %0d expected 0", display_select); end
    tick();
    checks++; if (count_A !== 4'd0 || count_B !== 4'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", count_A, count_B); end
    checks++; if ({mem_valid, busy, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {mem_valid, busy, error}); end
    reset_n = 1'b1;
    apply(K_NONE, 1'b0, 1'b0);
    checks++; if (strb !== S_NONE || display_select !== 2'd0) begin errors++; $display("FAIL post_reset_idle: got %h/%0d expected %h/0", strb, display_select, S_NONE); end
    tick();
  endtask

  task automatic test_digits();
    for (int i = 0; i < 5; i++) begin
      apply(K_DIG, 1'b0, 1'b0);
      checks++; if (strb !== ((i < 4) ? S_LA : S_NONE)) begin errors++; $display("FAIL dig_%0d_strobe: got %h expected %h", i, strb, (i < 4) ? S_LA : S_NONE); end
      tick();
      checks++; if (count_A !== 4'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL dig_%0d_count: got %0d expected %0d", i, count_A, (i < 4) ? i + 1 : 4); end
    end
    for (int i = 0; i < 5; i++) begin
      apply(K_BK, 1'b0, 1'b0);
      checks++; if (strb !== ((i < 4) ? S_BA : S_NONE)) begin errors++; $display("FAIL bksp_%0d_strobe: got %h expected %h", i, strb, (i < 4) ? S_BA : S_NONE); end
      tick();
      checks++; if (count_A !== 4'((i < 4) ? 3 - i : 0)) begin errors++; $display("FAIL bksp_%0d_count: got %0d expected %0d", i, count_A, (i < 4) ? 3 - i : 0); end
    end
  endtask

  task automatic test_exec();
    press(K_CLR);
    apply(K_DIG, 1'b0, 1'b0);
    checks++; if (strb !== S_LA) begin errors++; $display("FAIL exec_digA: got %h expected %h", strb, S_LA); end
    tick();
    apply(K_OP, 1'b0, 1'b0);
    checks++; if (strb !== S_LOP) begin errors++; $display("FAIL exec_op: got %h expected %h", strb, S_LOP); end
    tick();
    checks++; if (display_select !== 2'd0) begin errors++; $display("FAIL exec_opwait_disp: got %0d expected 0", display_select); end
    apply(K_DIG, 1'b0, 1'b0);
    checks++; if (strb !== S_LB) begin errors++; $display("FAIL exec_digB: got %h expected %h", strb, S_LB); end
    tick();
    checks++; if (display_select !== 2'd1 || count_B !== 4'd1) begin errors++; $display("FAIL exec_enterB: got disp %0d cntB %0d expected 1/1", display_select, count_B); end
    apply(K_EX, 1'b0, 1'b0);
    checks++; if (strb !== S_EXE) begin errors++; $display("FAIL exec_ex: got %h expected %h", strb, S_EXE); end
    tick();
    for (int j = 0; j < 3; j++) begin
      apply(K_NONE, (j == 2), 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exec_busy_%0d: got %b expected 1", j, busy); end
      checks++; if (strb !== S_NONE) begin errors++; $display("FAIL exec_quiet_%0d: got %h expected %h", j, strb, S_NONE); end
      tick();
    end
    checks++; if (busy !== 1'b0 || display_select !== 2'd2) begin errors++; $display("FAIL exec_result: got busy %b disp %0d expected 0/2", busy, display_select); end
  endtask

  task automatic test_timeout();
    go_exec();
    for (int i = 0; i < 16; i++) begin
      apply(K_NONE, 1'b0, 1'b0);
      checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL timeout_wait_%0d: got busy %b err %b expected 1/0", i, busy, error); end
      tick();
    end
    checks++; if (error !== 1'b1 || display_select !== 2'd3 || busy !== 1'b0) begin errors++; $display("FAIL timeout_err: got err %b disp %0d busy %b expected 1/3/0", error, display_select, busy); end
    apply(K_DIG, 1'b0, 1'b0);
    checks++; if (strb !== S_NONE) begin errors++; $display("FAIL err_dig_ignored: got %h expected %h", strb, S_NONE); end
    tick();
    checks++; if (display_select !== 2'd3) begin errors++; $display("FAIL err_hold: got %0d expected 3", display_select); end
    apply(K_CLR, 1'b0, 1'b0);
    checks++; if (strb !== S_CLR) begin errors++; $display("FAIL err_clear: got %h expected %h", strb, S_CLR); end
    tick();
    checks++; if (display_select !== 2'd0 || error !== 1'b0 || count_A !== 4'd0) begin errors++; $display("FAIL err_exit: got disp %0d err %b cntA %0d expected 0/0/0", display_select, error, count_A); end
  endtask

  task automatic test_alu_err();
    go_exec();
    apply(K_NONE, 1'b1, 1'b1);
    checks++; if (strb !== S_NONE) begin errors++; $display("FAIL aluerr_strobe: got %h expected %h", strb, S_NONE); end
    tick();
    checks++; if (error !== 1'b1 || display_select !== 2'd3) begin errors++; $display("FAIL aluerr_state: got err %b disp %0d expected 1/3", error, display_select); end
    press(K_CLR);
  endtask

  task automatic test_memory();
    go_exec();
    apply(K_NONE, 1'b1, 1'b0);
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL mem_initial: got %b expected 0", mem_valid); end
    apply(K_MS, 1'b0, 1'b0);
    checks++; if (strb !== S_MST) begin errors++; $display("FAIL mem_store: got %h expected %h", strb, S_MST); end
    tick();
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL mem_valid_set: got %b expected 1", mem_valid); end
    press(K_CLR);
    apply(K_MR, 1'b0, 1'b0);
    checks++; if (strb !== S_MRA) begin errors++; $display("FAIL mem_recall: got %h expected %h", strb, S_MRA); end
    tick();
    checks++; if (count_A !== 4'd4) begin errors++; $display("FAIL mem_recall_count: got %0d expected 4", count_A); end
    apply(K_MC, 1'b0, 1'b0);
    checks++; if (strb !== S_MCL) begin errors++; $display("FAIL mem_clear: got %h expected %h", strb, S_MCL); end
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL mem_valid_clr: got %b expected 0", mem_valid); end
    apply(K_MR, 1'b0, 1'b0);
    checks++; if (strb !== S_NONE) begin errors++; $display("FAIL mem_recall_empty: got %h expected %h", strb, S_NONE); end
    tick();
    checks++; if (count_A !== 4'd4) begin errors++; $display("FAIL mem_recall_empty_cnt: got %0d expected 4", count_A); end
  endtask

  task automatic test_chain();
    go_exec();
    apply(K_NONE, 1'b1, 1'b0);
    tick();
    apply(K_OP, 1'b0, 1'b0);
    checks++; if (strb !== (S_LAFR | S_LOP)) begin errors++; $display("FAIL chain_op: got %h expected %h", strb, S_LAFR | S_LOP); end
    tick();
    checks++; if (count_A !== 4'd4 || count_B !== 4'd0 || display_select !== 2'd0) begin errors++; $display("FAIL chain_state: got cntA %0d cntB %0d disp %0d expected 4/0/0", count_A, count_B, display_select); end
    apply(K_OP | K_DIG, 1'b0, 1'b0);
    checks++; if (strb !== S_LOP) begin errors++; $display("FAIL chain_op_dig: got %h expected %h", strb, S_LOP); end
    tick();
    checks++; if (count_B !== 4'd0 || display_select !== 2'd0) begin errors++; $display("FAIL chain_stay: got cntB %0d disp %0d expected 0/0", count_B, display_select); end
    apply(K_DIG, 1'b0, 1'b0);
    checks++; if (strb !== S_LB) begin errors++; $display("FAIL chain_digB: got %h expected %h", strb, S_LB); end
    tick();
    checks++; if (count_B !== 4'd1 || display_select !== 2'd1) begin errors++; $display("FAIL chain_enterB: got cntB %0d disp %0d expected 1/1", count_B, display_select); end
  endtask

  task automatic test_result_dig();
    go_exec();
    apply(K_NONE, 1'b1, 1'b0);
    tick();
    apply(K_DIG, 1'b0, 1'b0);
    checks++; if (strb !== (S_CLR | S_LA)) begin errors++; $display("FAIL result_dig: got %h expected %h", strb, S_CLR | S_LA); end
    tick();
    checks++; if (count_A !== 4'd1 || count_B !== 4'd0 || display_select !== 2'd0) begin errors++; $display("FAIL result_dig_state: got cntA %0d cntB %0d disp %0d expected 1/0/0", count_A, count_B, display_select); end
  endtask

  task automatic test_abort();
    go_exec();
    press(K_NONE);
    apply(K_CLR, 1'b0, 1'b0);
    checks++; if (strb !== S_CLR) begin errors++; $display("FAIL abort_clear: got %h expected %h", strb, S_CLR); end
    tick();
    checks++; if (busy !== 1'b0 || display_select !== 2'd0) begin errors++; $display("FAIL abort_state: got busy %b disp %0d expected 0/0", busy, display_select); end
    apply(K_NONE, 1'b1, 1'b0);
    checks++; if (strb !== S_NONE) begin errors++; $display("FAIL abort_late_done_strobe: got %h expected %h", strb, S_NONE); end
    tick();
    checks++; if (display_select !== 2'd0 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL abort_late_done: got disp %0d busy %b err %b expected 0/0/0", display_select, busy, error); end
    press(K_NONE);
    checks++; if (display_select !== 2'd0 || count_A !== 4'd0) begin errors++; $display("FAIL abort_hold: got disp %0d cntA %0d expected 0/0", display_select, count_A); end
  endtask

  task automatic test_enterB_bksp();
    press(K_CLR);
    press(K_DIG);
    press(K_OP);
    press(K_DIG);
    apply(K_BK, 1'b0, 1'b0);
    checks++; if (strb !== S_BB) begin errors++; $display("FAIL bkspB: got %h expected %h", strb, S_BB); end
    tick();
    apply(K_EX, 1'b0, 1'b0);
    checks++; if (strb !== S_NONE) begin errors++; $display("FAIL ex_emptyB: got %h expected %h", strb, S_NONE); end
    tick();
    apply(K_BK, 1'b0, 1'b0);
    checks++; if (strb !== S_NONE) begin errors++; $display("FAIL bkspB_empty: got %h expected %h", strb, S_NONE); end
    tick();
    checks++; if (display_select !== 2'd0) begin errors++; $display("FAIL bkspB_to_opwait: got %0d expected 0", display_select); end
  endtask

  initial begin
    reset_n     = 1'b0;
    alu_done_in = 1'b0;
    alu_err_in  = 1'b0;
    set_keys(K_NONE);
    test_reset();
    test_digits();
    test_exec();
    test_timeout();
    test_alu_err();
    test_memory();
    test_chain();
    test_result_dig();
    test_abort();
    test_enterB_bksp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
